// File: rtl/hyper_cord_range_reduce_if.sv
// Handshake bundle for the range-reduction stage: sample in, (q, r, sign) out.
// slave is the stage itself, master is whoever drives samples and drains results.
interface hyper_cord_range_reduce_if #(
    parameter int IDWIDTH     = 8,
    parameter int R_FRA_WIDTH = 14,
    parameter int Q_WIDTH     = 6
);
    logic                   iValid;
    logic                   oInReady;
    logic [IDWIDTH-1:0]     iData;
    logic                   oValid;
    logic                   iOutReady;
    logic [Q_WIDTH-1:0]     oQ;
    logic [R_FRA_WIDTH-1:0] oR;
    logic                   oSign;

    modport slave (
        input  iValid, iData, iOutReady,
        output oInReady, oValid, oQ, oR, oSign
    );

    modport master (
        output iValid, iData, iOutReady,
        input  oInReady, oValid, oQ, oR, oSign
    );
endinterface

// File: rtl/hyper_cord_range_reduce.sv
// Splits |x| = q*ln2 + r by repeated subtraction; result valid q+1 cycles after accept.
// One sample in flight; the result is held in DONE until the consumer takes it.
module hyper_cord_range_reduce #(
    parameter int IDWIDTH     = 8,
    parameter int R_FRA_WIDTH = 14,
    parameter int Q_WIDTH     = 6,
    parameter int LN2_CONST   = 11357
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    hyper_cord_range_reduce_if.slave   bus
);
    // Magnitude keeps IDWIDTH-2 integer bits plus the full residual fraction.
    localparam int MAG_W = (IDWIDTH - 2) + R_FRA_WIDTH;
    localparam int SHIFT = R_FRA_WIDTH - 2;

    localparam logic [MAG_W-1:0]   LN2_M  = MAG_W'(LN2_CONST);
    localparam logic [IDWIDTH-1:0] ONE_ID = IDWIDTH'(1);
    localparam logic [Q_WIDTH-1:0] ONE_Q  = Q_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MAG_W-1:0]       r_mag;
    logic [Q_WIDTH-1:0]     r_q;
    logic [Q_WIDTH-1:0]     r_out_q;
    logic [R_FRA_WIDTH-1:0] r_out_r;
    logic                   r_sign;
    logic                   r_valid;

    logic                   w_in_rdy;
    logic                   w_accept;
    logic [IDWIDTH-1:0]     w_abs;
    logic [MAG_W-1:0]       w_mag_load;
    logic                   w_ge;
    logic [MAG_W-1:0]       w_mag_sub;

    assign w_in_rdy = (r_state == S_IDLE);
    assign w_accept = bus.iValid && w_in_rdy;

    // Unsigned negate at full width: 0x80 becomes 128, not 0.
    assign w_abs      = bus.iData[IDWIDTH-1] ? ((~bus.iData) + ONE_ID) : bus.iData;
    assign w_mag_load = {{(MAG_W-IDWIDTH){1'b0}}, w_abs} << SHIFT;
    assign w_ge       = (r_mag >= LN2_M);
    assign w_mag_sub  = r_mag - LN2_M;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)       w_state_nxt = S_REDUCE;
            S_REDUCE: if (!w_ge)          w_state_nxt = S_DONE;
            S_DONE:   if (bus.iOutReady)  w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_mag   <= '0;
            r_q     <= '0;
            r_out_q <= '0;
            r_out_r <= '0;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= bus.iData[IDWIDTH-1];
                        r_mag  <= w_mag_load;
                        r_q    <= '0;
                    end
                end
                S_REDUCE: begin
                    if (w_ge) begin
                        r_mag <= w_mag_sub;
                        r_q   <= r_q + ONE_Q;
                    end else begin
                        // Residual is below ln2, so only fraction bits can be set.
                        r_out_r <= r_mag[R_FRA_WIDTH-1:0];
                        r_out_q <= r_q;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.iOutReady) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oInReady = w_in_rdy;
    assign bus.oValid   = r_valid;
    assign bus.oQ       = r_out_q;
    assign bus.oR       = r_out_r;
    assign bus.oSign    = r_sign;

endmodule

// File: tb/tb_hyper_cord_range_reduce.sv
// Bench for hyper_cord_range_reduce: directed vectors, random samples against an
// arithmetic model, backpressure, back-to-back handoff and mid-operation reset.
module tb_hyper_cord_range_reduce;
    localparam int IDWIDTH     = 8;
    localparam int R_FRA_WIDTH = 14;
    localparam int Q_WIDTH     = 6;
    localparam int LN2_CONST   = 11357;

    logic iClk = 1'b0;
    logic iRstN;
    int   errors = 0;
    int   checks = 0;

    always #5 iClk = ~iClk;

    hyper_cord_range_reduce_if #(
        .IDWIDTH(IDWIDTH), .R_FRA_WIDTH(R_FRA_WIDTH), .Q_WIDTH(Q_WIDTH)
    ) bus ();

    hyper_cord_range_reduce #(
        .IDWIDTH(IDWIDTH), .R_FRA_WIDTH(R_FRA_WIDTH),
        .Q_WIDTH(Q_WIDTH), .LN2_CONST(LN2_CONST)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus.slave)
    );

    // |x| in units of 2^-14 divided by ln2 in the same units.
    function automatic void model(input logic [7:0] d, output int q, output int r, output int s);
        int v;
        int mag;
        v = int'(d);
        if (v >= 128) v = 256 - v;
        mag = v * 4096;
        q = mag / LN2_CONST;
        r = mag % LN2_CONST;
        s = (d >= 8'h80) ? 1 : 0;
    endfunction

    task automatic drive_sample(input logic [7:0] d, output int lat, output bit timeout);
        int guard;
        guard = 0;
        @(negedge iClk);
        while (!bus.oInReady && guard < 200) begin
            @(negedge iClk);
            guard++;
        end
        bus.iValid = 1'b1;
        bus.iData  = d;
        @(posedge iClk);
        #1;
        bus.iValid = 1'b0;
        lat = 0;
        while (!bus.oValid && lat < 100) begin
            @(posedge iClk);
            #1;
            lat++;
        end
        timeout = !bus.oValid;
    endtask

    task automatic release_output();
        bus.iOutReady = 1'b1;
        @(posedge iClk);
        #1;
        bus.iOutReady = 1'b0;
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        bus.iValid = 1'b0;
        bus.iData = '0;
        bus.iOutReady = 1'b0;
        #12;
        checks++; if (bus.oValid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %0d expected 0", bus.oValid); end
        checks++; if (bus.oInReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %0d expected 1", bus.oInReady); end
        checks++; if (bus.oQ !== '0)         begin errors++; $display("FAIL reset_q: got %0d expected 0", bus.oQ); end
        checks++; if (bus.oR !== '0)         begin errors++; $display("FAIL reset_r: got %0d expected 0", bus.oR); end
        checks++; if (bus.oSign !== 1'b0)    begin errors++; $display("FAIL reset_sign: got %0d expected 0", bus.oSign); end
        @(negedge iClk);
        iRstN = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] vd [6] = '{8'h04, 8'hF6, 8'h80, 8'h7F, 8'h02, 8'h00};
        int         vq [6] = '{1, 3, 46, 45, 0, 0};
        int         vr [6] = '{5027, 6889, 1866, 9127, 8192, 0};
        int         vs [6] = '{0, 1, 1, 0, 0, 0};
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            drive_sample(vd[i], lat, to);
            checks++; if (to) begin errors++; $display("FAIL dir_timeout[%0h]: got no oValid expected oValid", vd[i]); end
            checks++; if (lat != vq[i] + 1) begin errors++; $display("FAIL dir_latency[%0h]: got %0d expected %0d", vd[i], lat, vq[i] + 1); end
            checks++; if (int'(bus.oQ) != vq[i]) begin errors++; $display("FAIL dir_q[%0h]: got %0d expected %0d", vd[i], bus.oQ, vq[i]); end
            checks++; if (int'(bus.oR) != vr[i]) begin errors++; $display("FAIL dir_r[%0h]: got %0d expected %0d", vd[i], bus.oR, vr[i]); end
            checks++; if (int'(bus.oSign) != vs[i]) begin errors++; $display("FAIL dir_sign[%0h]: got %0d expected %0d", vd[i], bus.oSign, vs[i]); end
            release_output();
            checks++; if (bus.oValid !== 1'b0 || bus.oInReady !== 1'b1) begin
                errors++; $display("FAIL dir_release[%0h]: got valid=%0d inready=%0d expected valid=0 inready=1", vd[i], bus.oValid, bus.oInReady);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int q, r, s, lat;
        bit to;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            model(d, q, r, s);
            drive_sample(d, lat, to);
            checks++; if (to || lat != q + 1) begin errors++; $display("FAIL rnd_latency[%0h]: got %0d expected %0d", d, lat, q + 1); end
            checks++; if (int'(bus.oQ) != q) begin errors++; $display("FAIL rnd_q[%0h]: got %0d expected %0d", d, bus.oQ, q); end
            checks++; if (int'(bus.oR) != r) begin errors++; $display("FAIL rnd_r[%0h]: got %0d expected %0d", d, bus.oR, r); end
            checks++; if (int'(bus.oSign) != s) begin errors++; $display("FAIL rnd_sign[%0h]: got %0d expected %0d", d, bus.oSign, s); end
            repeat ($urandom_range(0, 3)) @(posedge iClk);
            #1;
            release_output();
        end
    endtask

    task automatic test_backpressure_back_to_back();
        int lat;
        bit to;
        drive_sample(8'hF6, lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got no oValid expected oValid"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge iClk);
            #1;
            checks++;
            if (bus.oValid !== 1'b1 || bus.oQ !== 6'd3 || bus.oR !== 14'd6889 || bus.oSign !== 1'b1 || bus.oInReady !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0d q=%0d r=%0d s=%0d rdy=%0d expected v=1 q=3 r=6889 s=1 rdy=0",
                         i, bus.oValid, bus.oQ, bus.oR, bus.oSign, bus.oInReady);
            end
        end
        // New sample presented during the handoff cycle must wait for IDLE.
        bus.iOutReady = 1'b1;
        bus.iValid    = 1'b1;
        bus.iData     = 8'h04;
        @(posedge iClk);
        #1;
        bus.iOutReady = 1'b0;
        checks++; if (bus.oValid !== 1'b0 || bus.oInReady !== 1'b1) begin
            errors++; $display("FAIL b2b_handoff: got valid=%0d inready=%0d expected valid=0 inready=1", bus.oValid, bus.oInReady);
        end
        @(posedge iClk);
        #1;
        bus.iValid = 1'b0;
        checks++; if (bus.oInReady !== 1'b0) begin errors++; $display("FAIL b2b_accept: got inready=%0d expected 0", bus.oInReady); end
        lat = 0;
        while (!bus.oValid && lat < 100) begin
            @(posedge iClk);
            #1;
            lat++;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
        checks++; if (bus.oQ !== 6'd1 || bus.oR !== 14'd5027 || bus.oSign !== 1'b0) begin
            errors++; $display("FAIL b2b_result: got q=%0d r=%0d s=%0d expected q=1 r=5027 s=0", bus.oQ, bus.oR, bus.oSign);
        end
    endtask

    task automatic test_reset_mid_reduce();
        int lat;
        bit to;
        @(negedge iClk);
        bus.iValid = 1'b1;
        bus.iData  = 8'h80;
        @(posedge iClk);
        #1;
        bus.iValid = 1'b0;
        repeat (5) @(posedge iClk);
        #1;
        iRstN = 1'b0;
        #1;
        checks++; if (bus.oValid !== 1'b0 || bus.oInReady !== 1'b1) begin
            errors++; $display("FAIL mid_rst_ctrl: got valid=%0d inready=%0d expected valid=0 inready=1", bus.oValid, bus.oInReady);
        end
        checks++; if (bus.oQ !== '0 || bus.oR !== '0 || bus.oSign !== 1'b0) begin
            errors++; $display("FAIL mid_rst_data: got q=%0d r=%0d s=%0d expected 0 0 0", bus.oQ, bus.oR, bus.oSign);
        end
        repeat (3) @(posedge iClk);
        #1;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL mid_rst_hold: got valid=%0d expected 0", bus.oValid); end
        @(negedge iClk);
        iRstN = 1'b1;
        drive_sample(8'h04, lat, to);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL post_rst_latency: got %0d expected 2", lat); end
        checks++; if (bus.oQ !== 6'd1 || bus.oR !== 14'd5027 || bus.oSign !== 1'b0) begin
            errors++; $display("FAIL post_rst_result: got q=%0d r=%0d s=%0d expected q=1 r=5027 s=0", bus.oQ, bus.oR, bus.oSign);
        end
        release_output();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure_back_to_back();
        test_reset_mid_reduce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hyper_cord_range_reduce.md
Name: hyper_cord_range_reduce

Overview:
- Input range-reduction stage sitting directly upstream of the hyperbolic CORDIC core.
- Takes a signed Q5.2 sample and decomposes its magnitude as |x| = q*ln2 + r, with 0 <= r < ln2, by iterative subtraction.
- The core iterates only on r, which lies in its convergence range. The post-scale stage applies 2^q and the sign.
- Uses valid/ready handshakes on both sides and processes one sample at a time.

Parameters:
- IDWIDTH, 8, input width (1 sign + 5 integer + 2 fraction bits, two's complement); taken from hyperCord_pkg.
- R_FRA_WIDTH, 14, fraction bits of the internal residual and of oR.
- Q_WIDTH, 6, width of the quotient output.
- LN2_CONST, 11357, round(ln2 * 2^R_FRA_WIDTH), unsigned.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iValid  in  1  upstream sample valid.
- oInReady  out  1  block can accept a sample.
- iData  in  IDWIDTH  signed Q5.2 input.
- oValid  out  1  result valid.
- iOutReady  in  1  downstream ready.
- oQ  out  Q_WIDTH  quotient q, unsigned.
- oR  out  R_FRA_WIDTH  residual r, unsigned Q0.R_FRA_WIDTH.
- oSign  out  1  sign bit of the accepted iData.

Behaviour:
- Reset (async, iRstN=0):
  - state=IDLE, oValid=0, oInReady=1.
  - oQ, oR, oSign, internal magnitude and counter all cleared to 0.
  - Asserting reset mid-REDUCE or mid-DONE aborts the operation; nothing is emitted.
- States: IDLE, REDUCE, DONE.
- oInReady=1 only in IDLE.
- IDLE:
  - On iValid && oInReady, latch oSign = iData[IDWIDTH-1].
  - Compute the magnitude at full IDWIDTH unsigned width, so 0x80 (-32.0) gives 32.0 with no wrap to 0.
  - Load mag = magnitude << (R_FRA_WIDTH-2): unsigned, 6 integer + R_FRA_WIDTH fraction bits (20 bits).
  - Clear q; go to REDUCE.
- REDUCE (one decision per cycle):
  - If mag >= LN2_CONST: mag <= mag - LN2_CONST, q <= q+1, stay in REDUCE.
  - Else: oR <= mag[R_FRA_WIDTH-1:0], oQ <= q, oValid <= 1, go to DONE.
- DONE:
  - oQ/oR/oSign/oValid held stable while iOutReady=0 (unbounded backpressure).
  - On iOutReady=1: oValid <= 0, go to IDLE.
  - oInReady stays 0 in the handoff cycle, so a new accept happens at the earliest one cycle later.
- Latency: oValid rises q+1 rising edges after the accepting edge; minimum 1 (q=0), maximum 47 (q=46).
- Range: max q=46 (input 0x80), fits Q_WIDTH=6. Invariant r < LN2_CONST always holds. The comparison is unsigned, and mag never underflows.
- Zero input: q=0, r=0, oSign=0.
- Negative zero cannot occur.
- iData and iValid are ignored outside IDLE; no input buffering.

Test Plan:
- Reset, then iData=0x04 (+1.0) -> q=1, oR=5027, oSign=0; oValid 2 edges after accept.
- iData=0xF6 (-2.5) -> q=3, oR=6889, oSign=1; latency 4 edges.
- iData=0x80 (-32.0) -> q=46, oR=1866, oSign=1 (no magnitude wrap). iData=0x7F (+31.75) -> q=45, oR=9127.
- iData=0x02 (+0.5) -> q=0, oR=8192, latency 1. iData=0x00 -> q=0, oR=0, oSign=0.
- Backpressure: hold iOutReady=0 for 10 cycles after oValid -> outputs stable, oInReady=0. Release -> oValid drops next edge; a back-to-back iValid is accepted only once oInReady=1.
- Drop iRstN low mid-REDUCE on 0x80 -> outputs, state and oInReady return to reset values immediately. After release, a new 0x04 sample gives q=1, oR=5027.
